// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types and constants for the pipelined core's control logic.
//   - hazard_state_t : state of the hazard controller's halt sequencer
//   - LAT_*          : index of each pipeline latch in the latch_en /
//                      latch_flush vectors (latch i sits between stage i
//                      and stage i+1)
//   - src_match()    : one operand of a load-use comparison
//   Configuration macro: none (the HAZARD_PERF_EN option lives in the
//   hazard controller itself).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  localparam int LAT_IFID  = 0;
  localparam int LAT_IDEX  = 1;
  localparam int LAT_EXMEM = 2;
  localparam int LAT_MEMWB = 3;

  localparam int REG_ADDR_W = 5;

  // True when an ID-stage source operand is actually read and names the
  // register the EX-stage load is about to write.
  function automatic logic src_match(
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd
  );
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// ---------------------------------------------------------------------------
// hazard_perf_counters
//   Three free-running 32-bit event counters for the hazard controller.
//   Each counter advances by one on every clock where its increment strobe
//   is high and wraps naturally at 2^32. Cleared by the asynchronous reset.
//   The whole module only exists when HAZARD_PERF_EN is defined, so the
//   default build carries no unused top-level module.
// Ports
//   CLK             in   clock, rising edge
//   RST             in   asynchronous active-high reset
//   stall_inc       in   count one memory-stall cycle
//   bubble_inc      in   count one inserted bubble (load-use or imem miss)
//   flush_inc       in   count one taken-branch flush
//   perf_stall_cyc  out  memory-stall cycle count
//   perf_bubble_cnt out  bubble count
//   perf_flush_cnt  out  branch flush count
// Configuration macro: HAZARD_PERF_EN
// ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
module hazard_perf_counters (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_inc,
  input  logic        bubble_inc,
  input  logic        flush_inc,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [2:0]  inc;
  logic [31:0] cnt_reg [3];

  assign inc = {flush_inc, bubble_inc, stall_inc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_reg[gi] <= '0;
      end else if (inc[gi]) begin
        cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign perf_stall_cyc  = cnt_reg[0];
  assign perf_bubble_cnt = cnt_reg[1];
  assign perf_flush_cnt  = cnt_reg[2];

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush controller for the pipelined core. Drives the PC
//   load enable and a write-enable / clear-to-NOP pair for every pipeline
//   latch. Handles, in priority order: data-memory stall (full freeze),
//   taken branch (flush younger latches), load-use interlock (hold IF/ID,
//   bubble into EX) and instruction-memory miss (bubble into ID). A small
//   sequencer drains and then parks the pipe on a halt instruction, and a
//   watchdog flags a data-memory stall that lasts 2^WDOG_W-1 cycles.
// Parameters
//   NUM_STAGES  pipeline depth, 4..8 (latches = NUM_STAGES-1)
//   BR_STAGE    stage resolving branches, 1..NUM_STAGES-2
//   WDOG_W      width of the consecutive-stall counter
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   ihit              imem returned an instruction this cycle
//   dhit              dmem completed the MEM-stage access
//   dmemREN, dmemWEN  MEM-stage load / store request
//   halt              halt instruction in WB
//   ex_memread, ex_rd EX-stage load flag and destination register
//   id_rs, id_rt      ID-stage source registers
//   id_use_rs/_rt     ID instruction actually reads rs / rt
//   br_taken          redirect resolved in BR_STAGE
//   pc_en             PC load enable
//   latch_en          per-latch write enable
//   latch_flush       per-latch clear to NOP (meaningful only with latch_en)
//   halted            registered, sticky until reset
//   wdog_trip         registered, sticky stall-watchdog flag
//   perf_*            event counters (only with HAZARD_PERF_EN)
// Configuration macro: HAZARD_PERF_EN adds perf_stall_cyc, perf_bubble_cnt
//   and perf_flush_cnt; without it those ports and counters are absent.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 2,
  parameter int WDOG_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  dmemREN,
  input  logic                  dmemWEN,
  input  logic                  halt,
  input  logic                  ex_memread,
  input  logic [4:0]            ex_rd,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic [NUM_STAGES-2:0] latch_en,
  output logic [NUM_STAGES-2:0] latch_flush,
  output logic                  halted,
  output logic                  wdog_trip
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_bubble_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int NUM_LATCH = NUM_STAGES - 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  logic mem_req;
  logic mstall;
  logic lduse;

  assign mem_req = dmemREN | dmemWEN;
  assign mstall  = mem_req & ~dhit;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lduse = ex_memread && (ex_rd != '0) &&
                 (src_match(id_use_rs, id_rs, ex_rd) ||
                  src_match(id_use_rt, id_rt, ex_rd));

  // -------------------------------------------------------------------------
  // Per-latch masks for each hazard response
  // -------------------------------------------------------------------------
  logic [NUM_LATCH-1:0] br_flush_mask;     // latches feeding stages <= BR_STAGE
  logic [NUM_LATCH-1:0] lduse_en_mask;     // everything but IF/ID advances
  logic [NUM_LATCH-1:0] lduse_flush_mask;  // bubble enters EX
  logic [NUM_LATCH-1:0] imiss_flush_mask;  // bubble enters ID

  for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_mask
    // Latch gi feeds stage gi+1; the instructions younger than the branch
    // sit in stages 0..BR_STAGE-1 and land in latches 0..BR_STAGE-1.
    assign br_flush_mask[gi]    = (gi < BR_STAGE);
    assign lduse_en_mask[gi]    = (gi != LAT_IFID);
    assign lduse_flush_mask[gi] = (gi == LAT_IDEX);
    assign imiss_flush_mask[gi] = (gi == LAT_IFID);
  end

  // -------------------------------------------------------------------------
  // Halt sequencer state and watchdog registers
  // -------------------------------------------------------------------------
  hazard_state_t     state_reg;
  logic              halted_reg;
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic [WDOG_W-1:0] wdog_cnt_next;
  logic              wdog_trip_reg;

  // -------------------------------------------------------------------------
  // Stall / flush outputs. Outside RUN the pipe is completely frozen.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b0;
    latch_en    = '0;
    latch_flush = '0;
    if (state_reg == RUN) begin
      if (mstall) begin
        // Full freeze: nothing moves until memory answers.
        pc_en       = 1'b0;
        latch_en    = '0;
        latch_flush = '0;
      end else if (br_taken) begin
        // Branch beats load-use: the stalled ID instruction is squashed.
        pc_en       = 1'b1;
        latch_en    = '1;
        latch_flush = br_flush_mask;
      end else if (lduse) begin
        pc_en       = 1'b0;
        latch_en    = lduse_en_mask;
        latch_flush = lduse_flush_mask;
      end else if (!ihit) begin
        pc_en       = 1'b0;
        latch_en    = '1;
        latch_flush = imiss_flush_mask;
      end else begin
        pc_en       = 1'b1;
        latch_en    = '1;
        latch_flush = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Halt FSM: RUN -> DRAIN once the halt sees no memory stall, DRAIN ->
  // HALTED once any outstanding dmem access completes; HALTED is final.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (halt && !mstall) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_req || dhit) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED: begin
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign halted = halted_reg;

  // -------------------------------------------------------------------------
  // Watchdog: counts consecutive stall cycles, saturates at all-ones and
  // latches a sticky trip flag. Purely observational.
  // -------------------------------------------------------------------------
  always_comb begin
    wdog_cnt_next = '0;
    if (mstall) begin
      wdog_cnt_next = (wdog_cnt_reg == WDOG_MAX) ? wdog_cnt_reg
                                                 : wdog_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog_cnt_reg  <= '0;
      wdog_trip_reg <= 1'b0;
    end else begin
      wdog_cnt_reg  <= wdog_cnt_next;
      wdog_trip_reg <= wdog_trip_reg | (wdog_cnt_next == WDOG_MAX);
    end
  end

  assign wdog_trip = wdog_trip_reg;

  // -------------------------------------------------------------------------
  // Optional performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic stall_inc;
  logic bubble_inc;
  logic flush_inc;

  // Only events that actually shape the pipe are counted: a bubble or a
  // flush hidden behind a memory freeze does not happen that cycle.
  assign stall_inc  = mstall && (state_reg != HALTED);
  assign bubble_inc = (state_reg == RUN) && !mstall && !br_taken &&
                      (lduse || !ihit);
  assign flush_inc  = (state_reg == RUN) && !mstall && br_taken;

  hazard_perf_counters u_perf (
    .CLK             (CLK),
    .RST             (RST),
    .stall_inc       (stall_inc),
    .bubble_inc      (bubble_inc),
    .flush_inc       (flush_inc),
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Self-checking bench for pipeline_hazard_ctrl. Two instances share all
//   inputs: u_dut (BR_STAGE=2) and u_dut_b (BR_STAGE=3), both with WDOG_W=3
//   so the watchdog trips after 7 stall cycles. Expected values come from
//   spec constants and from a behavioural model of the stall rules.
//   Configuration macro: HAZARD_PERF_EN (perf counters also checked).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int L    = 4;
  localparam int WMAX = 7;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, dmemREN, dmemWEN, halt, ex_memread;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic       id_use_rs, id_use_rt, br_taken;

  logic         pc_en, halted, wdog_trip;
  logic [L-1:0] latch_en, latch_flush;
  logic         pc_en_b, halted_b, wdog_trip_b;
  logic [L-1:0] latch_en_b, latch_flush_b;
  logic [8:0]   ctrl, ctrl_b;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_bubble_cnt, perf_flush_cnt;
  logic [31:0] perf_stall_cyc_b, perf_bubble_cnt_b, perf_flush_cnt_b;
`endif

  assign ctrl   = {pc_en, latch_en, latch_flush};
  assign ctrl_b = {pc_en_b, latch_en_b, latch_flush_b};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.NUM_STAGES(5), .BR_STAGE(2), .WDOG_W(3)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .halt(halt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .br_taken(br_taken), .pc_en(pc_en), .latch_en(latch_en),
    .latch_flush(latch_flush), .halted(halted), .wdog_trip(wdog_trip)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pipeline_hazard_ctrl #(.NUM_STAGES(5), .BR_STAGE(3), .WDOG_W(3)) u_dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .halt(halt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .br_taken(br_taken), .pc_en(pc_en_b), .latch_en(latch_en_b),
    .latch_flush(latch_flush_b), .halted(halted_b), .wdog_trip(wdog_trip_b)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc_b), .perf_bubble_cnt(perf_bubble_cnt_b),
    .perf_flush_cnt(perf_flush_cnt_b)
`endif
  );

  // ---------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------
  int          m_phase;   // 0 running, 1 draining, 2 parked
  int          m_cnt;
  bit          m_trip, m_halted;
  int unsigned m_stall, m_bubble, m_flush;

  function automatic bit model_mstall();
    return (dmemREN || dmemWEN) && !dhit;
  endfunction

  function automatic bit model_lduse();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  // {pc_en, latch_en[3:0], latch_flush[3:0]} from the priority rules.
  function automatic logic [8:0] expect_ctrl(int br_stage);
    int all_en;
    all_en = (1 << L) - 1;
    if (m_phase != 0 || model_mstall()) return 9'd0;
    if (br_taken)      return 9'((1 << 8) | (all_en << 4) | ((1 << br_stage) - 1));
    if (model_lduse()) return 9'(((all_en - 1) << 4) | 2);
    if (!ihit)         return 9'((all_en << 4) | 1);
    return 9'((1 << 8) | (all_en << 4));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_trip = 0; m_halted = 0;
    m_stall = 0; m_bubble = 0; m_flush = 0;
  endtask

  task automatic model_advance();
    bit ms, lu;
    ms = model_mstall();
    lu = model_lduse();
    if (m_phase != 2 && ms) m_stall++;
    if (m_phase == 0 && !ms && !br_taken && (lu || !ihit)) m_bubble++;
    if (m_phase == 0 && !ms && br_taken) m_flush++;
    if (m_phase == 0 && halt && !ms) m_phase = 1;
    else if (m_phase == 1 && !ms) m_phase = 2;
    m_halted = (m_phase == 2);
    m_cnt = ms ? ((m_cnt < WMAX) ? m_cnt + 1 : WMAX) : 0;
    if (m_cnt == WMAX) m_trip = 1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------
  task automatic idle();
    ihit = 1; dhit = 0; dmemREN = 0; dmemWEN = 0; halt = 0; ex_memread = 0;
    ex_rd = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; br_taken = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 0;
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    tests_run++;
    if ({ctrl, halted, wdog_trip} !== 11'b1_1111_0000_0_0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b required %b", {ctrl, halted, wdog_trip}, 11'b1_1111_0000_0_0);
    end
    $display("[TB] reset: ctrl=%b halted=%b", ctrl, halted);
`ifdef HAZARD_PERF_EN
    tests_run++;
    if ({perf_stall_cyc, perf_bubble_cnt, perf_flush_cnt} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d/%0d required 0/0/0", perf_stall_cyc, perf_bubble_cnt, perf_flush_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_mstall();
    dmemREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests_run++;
      if (ctrl !== 9'b0_0000_0000) begin
        tests_failed++;
        $display("FAIL mstall_freeze[%0d]: got %b required %b", i, ctrl, 9'b0_0000_0000);
      end
      $display("[TB] mstall cycle %0d: ctrl=%b", i, ctrl);
      tick();
    end
    dhit = 1;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b1_1111_0000) begin
      tests_failed++;
      $display("FAIL mstall_release: got %b required %b", ctrl, 9'b1_1111_0000);
    end
    $display("[TB] mstall dhit: ctrl=%b", ctrl);
    tick();
    idle();
  endtask

  task automatic test_lduse();
    ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b0_1110_0010) begin
      tests_failed++;
      $display("FAIL lduse_rs: got %b required %b", ctrl, 9'b0_1110_0010);
    end
    $display("[TB] lduse rs: ctrl=%b", ctrl);
    tick();
    ex_rd = 0; id_rs = 0;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b1_1111_0000) begin
      tests_failed++;
      $display("FAIL lduse_r0: got %b required %b", ctrl, 9'b1_1111_0000);
    end
    $display("[TB] lduse r0: ctrl=%b", ctrl);
    tick();
    ex_rd = 7; id_rs = 3; id_rt = 7; id_use_rs = 1; id_use_rt = 1;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b0_1110_0010) begin
      tests_failed++;
      $display("FAIL lduse_rt: got %b required %b", ctrl, 9'b0_1110_0010);
    end
    $display("[TB] lduse rt: ctrl=%b", ctrl);
    tick();
    id_use_rt = 0;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b1_1111_0000) begin
      tests_failed++;
      $display("FAIL lduse_rt_unused: got %b required %b", ctrl, 9'b1_1111_0000);
    end
    $display("[TB] lduse rt unused: ctrl=%b", ctrl);
    tick();
    idle();
  endtask

  task automatic test_branch();
    ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; br_taken = 1;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b1_1111_0011) begin
      tests_failed++;
      $display("FAIL branch_over_lduse: got %b required %b", ctrl, 9'b1_1111_0011);
    end
    tests_run++;
    if (ctrl_b !== 9'b1_1111_0111) begin
      tests_failed++;
      $display("FAIL branch_br3: got %b required %b", ctrl_b, 9'b1_1111_0111);
    end
    $display("[TB] branch: ctrl=%b ctrl_b=%b", ctrl, ctrl_b);
    tick();
    idle();
    ihit = 0;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b0_1111_0001) begin
      tests_failed++;
      $display("FAIL imiss: got %b required %b", ctrl, 9'b0_1111_0001);
    end
    $display("[TB] imiss: ctrl=%b", ctrl);
    tick();
    idle();
    br_taken = 1; dmemWEN = 1; dhit = 0;
    @(negedge CLK);
    tests_run++;
    if (ctrl !== 9'b0_0000_0000) begin
      tests_failed++;
      $display("FAIL branch_under_mstall: got %b required %b", ctrl, 9'b0_0000_0000);
    end
    $display("[TB] branch under mstall: ctrl=%b", ctrl);
    tick();
    idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    dmemREN = 1; dhit = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      tests_run++;
      if (wdog_trip !== 1'b0) begin
        tests_failed++;
        $display("FAIL wdog_early[%0d]: got %b required 0", k, wdog_trip);
      end
      $display("[TB] wdog cycle %0d: trip=%b", k, wdog_trip);
      tick();
    end
    @(negedge CLK);
    tests_run++;
    if (wdog_trip !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdog_trip_cycle8: got %b required 1", wdog_trip);
    end
    tests_run++;
    if (ctrl !== 9'b0_0000_0000) begin
      tests_failed++;
      $display("FAIL wdog_no_effect: got %b required %b", ctrl, 9'b0_0000_0000);
    end
`ifdef HAZARD_PERF_EN
    tests_run++;
    if (perf_stall_cyc !== 32'd7) begin
      tests_failed++;
      $display("FAIL perf_stall_7: got %0d required 7", perf_stall_cyc);
    end
`endif
    $display("[TB] wdog cycle 8: trip=%b", wdog_trip);
    tick();
    dhit = 1;
    tick();
    idle();
    tick();
    @(negedge CLK);
    tests_run++;
    if (wdog_trip !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdog_sticky: got %b required 1", wdog_trip);
    end
    $display("[TB] wdog after dhit: trip=%b", wdog_trip);
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ihit       = ($urandom_range(0, 9) != 0);
      dmemREN    = ($urandom_range(0, 3) == 0);
      dmemWEN    = ($urandom_range(0, 7) == 0);
      dhit       = ($urandom_range(0, 2) != 0);
      halt       = 0;
      ex_memread = $urandom_range(0, 1);
      ex_rd      = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_use_rs  = $urandom_range(0, 1);
      id_use_rt  = $urandom_range(0, 1);
      br_taken   = ($urandom_range(0, 4) == 0);
      @(negedge CLK);
      tests_run++;
      if ({ctrl, ctrl_b, halted, wdog_trip} !== {expect_ctrl(2), expect_ctrl(3), m_halted, m_trip}) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %b/%b/%b%b required %b/%b/%b%b", n, ctrl, ctrl_b, halted, wdog_trip,
                 expect_ctrl(2), expect_ctrl(3), m_halted, m_trip);
      end
`ifdef HAZARD_PERF_EN
      tests_run++;
      if ({perf_stall_cyc, perf_bubble_cnt, perf_flush_cnt} !== {m_stall, m_bubble, m_flush}) begin
        tests_failed++;
        $display("FAIL random_perf[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", n,
                 perf_stall_cyc, perf_bubble_cnt, perf_flush_cnt, m_stall, m_bubble, m_flush);
      end
`endif
      $display("[TB] random %0d: ctrl=%b ctrl_b=%b trip=%b", n, ctrl, ctrl_b, wdog_trip);
      tick();
    end
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    halt = 1; dmemWEN = 1; dhit = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      tests_run++;
      if ({ctrl, halted} !== 10'b0_0000_0000_0) begin
        tests_failed++;
        $display("FAIL halt_held_in_run[%0d]: got %b required %b", i, {ctrl, halted}, 10'b0_0000_0000_0);
      end
      $display("[TB] halt under mstall %0d: ctrl=%b halted=%b", i, ctrl, halted);
      tick();
    end
    dhit = 1;
    @(negedge CLK);
    tests_run++;
    if ({ctrl, halted} !== 10'b1_1111_0000_0) begin
      tests_failed++;
      $display("FAIL halt_dhit_cycle: got %b required %b", {ctrl, halted}, 10'b1_1111_0000_0);
    end
    tick();
    dmemWEN = 0; dhit = 0;
    @(negedge CLK);
    tests_run++;
    if ({ctrl, halted} !== 10'b0_0000_0000_0) begin
      tests_failed++;
      $display("FAIL halt_drain: got %b required %b", {ctrl, halted}, 10'b0_0000_0000_0);
    end
    $display("[TB] drain: ctrl=%b halted=%b", ctrl, halted);
    tick();
    idle();
    br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests_run++;
      if ({ctrl, halted, halted_b} !== 11'b0_0000_0000_1_1) begin
        tests_failed++;
        $display("FAIL halted_sticky[%0d]: got %b required %b", i, {ctrl, halted, halted_b}, 11'b0_0000_0000_1_1);
      end
      $display("[TB] halted %0d: ctrl=%b halted=%b", i, ctrl, halted);
      tick();
    end
`ifdef HAZARD_PERF_EN
    tests_run++;
    if (perf_flush_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_frozen_halted: got %0d required 0", perf_flush_cnt);
    end
`endif
    idle();
  endtask

  task automatic test_async_reset();
    // Reset taking effect between clock edges proves it is asynchronous.
    RST = 1;
    model_reset();
    #1;
    tests_run++;
    if ({halted, wdog_trip, ctrl} !== {2'b00, 9'b1_1111_0000}) begin
      tests_failed++;
      $display("FAIL async_reset: got %b required %b", {halted, wdog_trip, ctrl}, {2'b00, 9'b1_1111_0000});
    end
    $display("[TB] async reset: halted=%b ctrl=%b", halted, ctrl);
    @(posedge CLK);
    #1;
    RST = 0;
    // Partial stall then a reset mid-stall: the count must restart.
    dmemREN = 1; dhit = 0;
    for (int i = 0; i < 4; i++) tick();
    RST = 1;
    model_reset();
    #2;
    RST = 0;
    for (int i = 0; i < 6; i++) tick();
    @(negedge CLK);
    tests_run++;
    if (wdog_trip !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdog_cleared_by_reset: got %b required 0", wdog_trip);
    end
    $display("[TB] stall after mid-stall reset: trip=%b", wdog_trip);
    tick();
    @(negedge CLK);
    tests_run++;
    if (wdog_trip !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdog_after_reset_trip: got %b required 1", wdog_trip);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    RST = 1;
    model_reset();
    @(posedge CLK);
    #1;
    test_reset();
    test_mstall();
    test_lduse();
    test_branch();
    test_watchdog();
    test_random();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
